tx_frame_arbiter: RTL and testbench
===================================

TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter WORDS_PER_FRAME SHALL default to 3 and SHALL set the number of 32-bit words per 96-bit packager payload frame; legal range is 1..255.
REQ-003 Parameter TIMEOUT_CYCLES SHALL default to 255 and SHALL set the mid-frame source starvation limit in cycles; legal range is 1..65535.
REQ-004 Port list, one per line:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  s0_valid  in  1  source 0 AXIS TVALID
  s0_data  in  32  source 0 AXIS TDATA
  s0_ready  out  1  source 0 AXIS TREADY
  s1_valid  in  1  source 1 AXIS TVALID
  s1_data  in  32  source 1 AXIS TDATA
  s1_ready  out  1  source 1 AXIS TREADY
  m_valid  out  1  to packager fifo input, AXIS TVALID
  m_data  out  32  to packager fifo input, AXIS TDATA
  m_ready  in  1  from packager fifo input, AXIS TREADY
  grant  out  2  one-hot current owner, 00 when idle
  pad_err  out  1  one-cycle pulse when a timeout forces padding

Function
REQ-005 The FSM SHALL have exactly three states: ST_IDLE, ST_FWD and ST_PAD.
REQ-006 In ST_IDLE the outputs SHALL be m_valid=0, s0_ready=0, s1_ready=0 and grant=00.
REQ-007 In ST_IDLE, if any sX_valid=1, the block SHALL register the selected source and enter ST_FWD on the next edge, giving 1 cycle of arbitration latency before the first transfer is possible.
REQ-008 Round-robin rule: when both sources are valid, the source that is not last_src SHALL win; when only one source is valid, that source SHALL win.
REQ-009 In ST_FWD the datapath SHALL be combinational pass-through: m_valid=s_sel_valid, m_data=s_sel_data and s_sel_ready=m_ready.
REQ-010 In ST_FWD the non-selected source's ready SHALL be 0, and grant SHALL be one-hot for the selected source.
REQ-011 word_cnt SHALL increment on each m_valid&m_ready cycle.
REQ-012 A handshake with word_cnt==WORDS_PER_FRAME-1 SHALL clear word_cnt, set last_src to the selected source, and return the FSM to ST_IDLE.
REQ-013 Arbitration SHALL take place only in ST_IDLE, so a frame is never split between sources.
REQ-014 stall_cnt SHALL increment only in ST_FWD cycles with s_sel_valid=0.
REQ-015 stall_cnt SHALL clear on any handshake and on leaving ST_FWD.
REQ-016 Back-pressure (m_ready=0 while the source is valid) SHALL NOT advance stall_cnt.
REQ-017 When stall_cnt reaches TIMEOUT_CYCLES, the FSM SHALL enter ST_PAD and pad_err SHALL pulse high for exactly that one cycle.
REQ-018 In ST_PAD the outputs SHALL be m_valid=1, m_data=32'h0000_0000, s0_ready=0 and s1_ready=0, with grant held on the stalled source.
REQ-019 In ST_PAD word_cnt SHALL continue counting, and the handshake with word_cnt==WORDS_PER_FRAME-1 SHALL return the FSM to ST_IDLE and update last_src.
REQ-020 A source becoming valid during ST_FWD or ST_PAD SHALL wait, with its ready held at 0.
REQ-021 A source dropping valid mid-frame without timing out SHALL resume the same frame.
REQ-022 m_valid, once asserted in ST_PAD, SHALL stay asserted until m_ready; in ST_FWD, AXIS stability of valid is the source's obligation.

Reset
REQ-023 While rst=1 at a clk edge, the state SHALL become ST_IDLE, word_cnt=0, stall_cnt=0, last_src=1 (so s0 wins the first tie), grant=00 and pad_err=0.
REQ-024 While rst=1, m_valid, s0_ready and s1_ready SHALL be 0 combinationally.
REQ-025 Reset asserted mid-frame SHALL abandon the partial frame without padding; the downstream packager is reset together with this block.

Configuration
REQ-026 Macro ARB_S0_PRIORITY_EN defined: in ST_IDLE, s0 SHALL win whenever s0_valid=1, regardless of last_src (strict priority).
REQ-027 Macro ARB_S0_PRIORITY_EN undefined: REQ-008 round-robin SHALL apply; last_src SHALL still be tracked in both builds.

Verification
REQ-028 Reset, then s0 alone presents words A1,A2,A3 with m_ready=1 -> grant=01 from cycle 2; m_data A1,A2,A3 on 3 consecutive cycles; then grant=00.
REQ-029 s0 and s1 both continuously valid, 4 frames -> owners s0,s1,s0,s1 (round-robin build) or s0,s0,s0,s0 (ARB_S0_PRIORITY_EN build); never fewer than 3 words per owner.
REQ-030 s1 granted, sends 1 word, then s1_valid=0 for 255 cycles -> pad_err pulses once; two 32'h0 words follow; grant returns to 00.
REQ-031 s0 granted, m_ready=0 for 1000 cycles with s0_valid=1 -> no pad_err; frame completes with s0 data once m_ready=1.
REQ-032 rst pulsed after word 2 of a frame -> next cycle m_valid=0 and grant=00; next frame starts at word_cnt 0, with s0 winning a tie.

Source files
------------

// File: rtl/tx_frame_arbiter.sv
// Two-source AXIS round-robin frame arbiter feeding the 96-bit payload packager FIFO; a starved source's frame is zero-padded.
// Latency: 1 cycle of arbitration in ST_IDLE, then combinational pass-through per word.
// Backpressure: m_ready passes straight to the owning source; ST_PAD holds m_valid until accepted. Build option ARB_S0_PRIORITY_EN.
module tx_frame_arbiter #(
    parameter int WORDS_PER_FRAME = 3,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    input  logic [31:0] s0_data,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [31:0] s1_data,
    output logic        s1_ready,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready,
    output logic [1:0]  grant,
    output logic        pad_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        sel;          // current owner: 0 = s0, 1 = s1
    logic        sel_nxt;
    logic        last_src;     // owner of the most recently completed frame
    logic [7:0]  word_cnt;
    logic [15:0] stall_cnt;
    logic        sel_valid;
    logic [31:0] sel_data;
    logic        xfer;         // a word leaves this cycle
    logic        last_word;
    logic        timeout;

    assign sel_valid = sel ? s1_valid : s0_valid;
    assign sel_data  = sel ? s1_data  : s0_data;
    assign last_word = (word_cnt == 8'(WORDS_PER_FRAME - 1));

    // Outputs per state, then next state; reset forces the handshake signals low.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        m_valid   = 1'b0;
        m_data    = 32'h0000_0000;
        s0_ready  = 1'b0;
        s1_ready  = 1'b0;
        grant     = 2'b00;
        timeout   = 1'b0;
        xfer      = 1'b0;

        case (state)
            ST_FWD: begin
                m_valid  = sel_valid;
                m_data   = sel_data;
                s0_ready = !sel && m_ready;
                s1_ready = sel && m_ready;
                grant    = sel ? 2'b10 : 2'b01;
            end
            ST_PAD: begin
                m_valid = 1'b1;
                grant   = sel ? 2'b10 : 2'b01;
            end
            default: ;
        endcase

        if (rst) begin
            m_valid  = 1'b0;
            s0_ready = 1'b0;
            s1_ready = 1'b0;
        end

        xfer = m_valid && m_ready;

        case (state)
            ST_IDLE: begin
                if (s0_valid || s1_valid) begin
                    state_nxt = ST_FWD;
`ifdef ARB_S0_PRIORITY_EN
                    sel_nxt = !s0_valid;
`else
                    if (s0_valid && s1_valid) sel_nxt = !last_src;
                    else                      sel_nxt = s1_valid;
`endif
                end
            end
            ST_FWD: begin
                if (xfer && last_word) begin
                    state_nxt = ST_IDLE;
                end else if (!sel_valid && stall_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = ST_PAD;
                    timeout   = 1'b1;
                end
            end
            ST_PAD: begin
                if (xfer && last_word) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Owner, frame position, starvation counter and the pad error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel       <= 1'b0;
            last_src  <= 1'b1;   // s0 wins the first tie after reset
            word_cnt  <= 8'd0;
            stall_cnt <= 16'd0;
            pad_err   <= 1'b0;
        end else begin
            sel     <= sel_nxt;
            pad_err <= timeout;
            if (xfer) begin
                if (last_word) begin
                    word_cnt <= 8'd0;
                    last_src <= sel;
                end else begin
                    word_cnt <= word_cnt + 8'd1;
                end
            end
            // Only a silent owner counts as starvation; downstream backpressure does not.
            if (state == ST_FWD && state_nxt == ST_FWD && !xfer && !sel_valid)
                stall_cnt <= stall_cnt + 16'd1;
            else
                stall_cnt <= 16'd0;
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Randomized scoreboard bench for tx_frame_arbiter: frame-level reference model, decoupled monitor.
// Latency: checks the 1-cycle arbitration gap and back-to-back word flow.
// Backpressure: random m_ready, long m_ready stalls, and a starved-source padding case.
module tb_tx_frame_arbiter;

    localparam int W  = 3;
    localparam int TO = 255;
`ifdef ARB_S0_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s1_valid, s0_ready, s1_ready;
    logic [31:0] s0_data, s1_data;
    logic        m_valid, m_ready;
    logic [31:0] m_data;
    logic [1:0]  grant;
    logic        pad_err;

    always #5 clk = ~clk;

    tx_frame_arbiter #(.WORDS_PER_FRAME(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .grant(grant), .pad_err(pad_err)
    );

    typedef struct {
        logic [31:0] dat;
        logic [1:0]  gnt;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];
    int   cyc     = 0;
    int   pad_cnt = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   gap_max = 0;
    int   last_m  = 1;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Source drivers: AXIS-compliant; random gaps only strictly inside a frame.
    for (genvar g = 0; g < 2; g++) begin : drv
        logic        v = 1'b0;
        logic [31:0] d = 32'h0;
        logic [31:0] q[$];
        int          acc = 0;
        int          gap = 0;
        logic        hs;
        wire         rdy = (g == 0) ? s0_ready : s1_ready;

        initial forever begin
            @(negedge clk);
            hs = v & rdy;
            @(posedge clk);
            #1;
            if (rst) begin
                q.delete();
                acc = 0;
                gap = 0;
                v   = 1'b0;
            end else begin
                if (hs) begin
                    void'(q.pop_front());
                    acc++;
                    if (gap_max > 0 && (acc % W) != 0) gap = $urandom_range(gap_max, 0);
                end
                if (gap > 0) begin
                    gap--;
                    v = 1'b0;
                end else if (q.size() > 0) begin
                    v = 1'b1;
                    d = q[0];
                end else begin
                    v = 1'b0;
                end
            end
        end
    end

    assign s0_valid = drv[0].v;
    assign s0_data  = drv[0].d;
    assign s1_valid = drv[1].v;
    assign s1_data  = drv[1].d;

    // Monitor: every accepted output word is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (pad_err) pad_cnt++;
            if (m_valid && m_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_word: got %h expected none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e.dat);
                    chk("grant", 32'(grant), 32'(e.gnt));
                end
            end
        end
    end

    // Reference model: whole frames, round-robin (or s0 priority) among sources with data left.
    task automatic run_frames(input int f0, input int f1);
        logic [31:0] w0[$];
        logic [31:0] w1[$];
        logic [31:0] w;
        int r0 = f0;
        int r1 = f1;
        int own;
        exp_t x;
        for (int i = 0; i < f0 * W; i++) begin
            w = {8'hA0, 24'($urandom)};
            w0.push_back(w);
            drv[0].q.push_back(w);
        end
        for (int i = 0; i < f1 * W; i++) begin
            w = {8'hB1, 24'($urandom)};
            w1.push_back(w);
            drv[1].q.push_back(w);
        end
        while (r0 + r1 > 0) begin
            if (r0 > 0 && r1 > 0) own = PRIO ? 0 : 1 - last_m;
            else                  own = (r0 > 0) ? 0 : 1;
            for (int k = 0; k < W; k++) begin
                x.dat = (own == 1) ? w1.pop_front() : w0.pop_front();
                x.gnt = (own == 1) ? 2'b10 : 2'b01;
                exp_q.push_back(x);
            end
            if (own == 1) r1--; else r0--;
            last_m = own;
        end
    endtask

    task automatic wait_empty(input int budget, input bit rnd_ready, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            if (rnd_ready) m_ready = ($urandom_range(3, 0) != 0);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        m_ready = 1'b1;
    endtask

    initial begin
        exp_t x;
        int   c;
        logic [31:0] w;

        rst     = 1'b1;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s0_ready", 32'(s0_ready), 32'd0);
        chk("rst_s1_ready", 32'(s1_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_pad_err", 32'(pad_err), 32'd0);

        // Single s0 frame: one arbitration cycle, then three consecutive words.
        m_ready = 1'b1;
        @(negedge clk);
        hs_cyc.delete();
        c = cyc;
        run_frames(1, 0);
        wait_empty(50, 1'b0, "single_drain");
        for (int i = 0; i < 3; i++)
            chk("single_word_cycle", (hs_cyc.size() > i) ? 32'(hs_cyc[i]) : 32'hFFFF_FFFF, 32'(c + 2 + i));
        @(negedge clk);
        chk("single_idle_grant", 32'(grant), 32'd0);

        // Random contention with mid-frame gaps and random backpressure.
        gap_max = 6;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            run_frames($urandom_range(5, 2), $urandom_range(5, 2));
            wait_empty(3000, 1'b1, "rand_drain");
        end
        gap_max = 0;
        chk("rand_no_pad", 32'(pad_cnt), 32'd0);

        // Long backpressure must not count as starvation.
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        run_frames(1, 0);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("bp_no_pad", 32'(pad_cnt), 32'd0);
        chk("bp_words_held", 32'(exp_q.size()), 32'd3);
        chk("bp_grant", 32'(grant), 32'd1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_empty(50, 1'b0, "bp_drain");

        // s1 sends one word then starves: two zero pad words follow.
        @(negedge clk);
        w = {8'hB1, 24'($urandom)};
        drv[1].q.push_back(w);
        x.gnt = 2'b10;
        x.dat = w;     exp_q.push_back(x);
        x.dat = 32'h0; exp_q.push_back(x);
        x.dat = 32'h0; exp_q.push_back(x);
        last_m = 1;
        wait_empty(TO + 100, 1'b0, "timeout_drain");
        chk("timeout_pad_pulses", 32'(pad_cnt), 32'd1);
        @(negedge clk);
        chk("timeout_idle_grant", 32'(grant), 32'd0);

        // Reset after word 2 abandons the frame; the next tie goes to s0.
        @(negedge clk);
        x.gnt = 2'b01;
        for (int i = 0; i < 2; i++) begin
            w = {8'hA0, 24'($urandom)};
            drv[0].q.push_back(w);
            x.dat = w;
            exp_q.push_back(x);
        end
        wait_empty(50, 1'b0, "partial_drain");
        @(negedge clk);
        chk("partial_grant_held", 32'(grant), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_comb_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_m_valid", 32'(m_valid), 32'd0);
        chk("post_rst_grant", 32'(grant), 32'd0);
        last_m = 1;
        @(negedge clk);
        run_frames(1, 1);
        wait_empty(100, 1'b0, "tie_drain");
        chk("final_pad_pulses", 32'(pad_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
